// File: rtl/konami_cs_decoder.sv
// konami_cs_decoder: registered chip-select generator with per-region
// wait states. Optional macro: KONAMI_CSDEC_BUSERR_EN (enables bus_err).
module konami_cs_decoder #(
   parameter int ADDR_W = 16,
   parameter int NUM_CS = 4,
   parameter int WS_W = 3,
   parameter logic [NUM_CS*ADDR_W-1:0] CS_BASE = 64'h4000_0000_0000_5F80,
   parameter logic [NUM_CS*ADDR_W-1:0] CS_MASK = 64'hC000_FC00_FC00_FF80,
   parameter logic [NUM_CS*WS_W-1:0] CS_WS = 12'h081,
   parameter logic [2*NUM_CS-1:0] CS_QUAL = 8'h24,
   localparam int IDX_W = $clog2(NUM_CS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rmrd,
   output logic [NUM_CS-1:0] cs_n,
   output logic              ack,
   output logic              bus_err,
   output logic [IDX_W-1:0]  hit_idx,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_HOLD
   } state_t;

   state_t            state;
   logic [WS_W-1:0]   cnt;
   logic [NUM_CS-1:0] match;
   logic              hit;
   logic [IDX_W-1:0]  hit_sel;
   logic [WS_W-1:0]   ws_sel;

   // Per-region address window compare, qualified by rmrd
   for (genvar i = 0; i < NUM_CS; i++) begin : g_match
      localparam logic [ADDR_W-1:0] BASE = CS_BASE[i*ADDR_W +: ADDR_W];
      localparam logic [ADDR_W-1:0] MASK = CS_MASK[i*ADDR_W +: ADDR_W];
      localparam logic [1:0] QUAL = CS_QUAL[2*i +: 2];
      logic win;
      logic qual_ok;
      assign win = (addr & MASK) == (BASE & MASK);
      assign qual_ok = (QUAL == 2'b00)
                    || ((QUAL == 2'b01) && !rmrd)
                    || ((QUAL == 2'b10) && rmrd);
      assign match[i] = win && qual_ok;
   end

   // Priority select: scanning downward lets the lowest index win
   always_comb begin
      hit = 1'b0;
      hit_sel = '0;
      ws_sel = '0;
      for (int i = NUM_CS - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit = 1'b1;
            hit_sel = IDX_W'(i);
            ws_sel = CS_WS[i*WS_W +: WS_W];
         end
      end
   end

   // Transaction FSM with registered chip selects, ack and busy
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt <= '0;
         cs_n <= '1;
         ack <= 1'b0;
         hit_idx <= '0;
         busy <= 1'b0;
      end else begin
         ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  state <= S_WAIT;
                  busy <= 1'b1;
                  cnt <= hit ? ws_sel : '0;
                  cs_n <= hit ? ~(NUM_CS'(1) << hit_sel) : '1;
                  hit_idx <= hit ? hit_sel : '0;
               end
            end
            S_WAIT: begin
               if (!req) begin
                  state <= S_IDLE;
                  busy <= 1'b0;
                  cs_n <= '1;
                  cnt <= '0;
               end else if (cnt == '0) begin
                  state <= S_ACK;
                  ack <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            S_ACK: begin
               state <= S_HOLD;
            end
            S_HOLD: begin
               if (!req) begin
                  state <= S_IDLE;
                  busy <= 1'b0;
                  cs_n <= '1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy <= 1'b0;
               cs_n <= '1;
            end
         endcase
      end
   end

`ifdef KONAMI_CSDEC_BUSERR_EN
   logic miss;

   // Remember a missed decode and flag it alongside its ack
   always_ff @(posedge clk) begin
      if (reset) begin
         miss <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         if (state == S_IDLE && req) begin
            miss <= !hit;
         end
         bus_err <= (state == S_WAIT) && req && (cnt == '0) && miss;
      end
   end
`else
   assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_konami_cs_decoder.sv
// Self-checking bench for konami_cs_decoder: directed vector table
// plus reset, abort, late-release and mid-transaction reset sequences.
module tb_konami_cs_decoder;

   localparam logic ERR_EXP =
`ifdef KONAMI_CSDEC_BUSERR_EN
      1'b1;
`else
      1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [15:0] addr;
   logic        rmrd;
   logic [3:0]  cs_n;
   logic        ack;
   logic        bus_err;
   logic [1:0]  hit_idx;
   logic        busy;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   konami_cs_decoder dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .addr(addr),
      .rmrd(rmrd),
      .cs_n(cs_n),
      .ack(ack),
      .bus_err(bus_err),
      .hit_idx(hit_idx),
      .busy(busy)
   );

   typedef struct {
      logic [15:0] addr;
      logic        rmrd;
      logic [3:0]  cs;
      logic [1:0]  idx;
      logic        chk_idx;
      int          ack_cyc;
      logic        err;
   } vec_t;

   vec_t v[12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wait for ack from cycle T1; returns the cycle number it appeared in
   task automatic wait_ack(input string name, output int cyc);
      cyc = 1;
      while (!ack && cyc < 12) begin
         tick();
         cyc++;
      end
      if (!ack) $display("FAIL %s: no ack within bound", name);
   endtask

   task automatic run_vec(input int k);
      string n;
      int cyc;
      n = $sformatf("v%0d", k);
      addr = v[k].addr;
      rmrd = v[k].rmrd;
      req = 1'b1;
      tick();
      chk({n, " cs_n T1"}, 32'(cs_n), 32'(v[k].cs));
      chk({n, " busy T1"}, 32'(busy), 32'd1);
      chk({n, " ack T1"}, 32'(ack), 32'd0);
      if (v[k].chk_idx)
         chk({n, " hit_idx"}, 32'(hit_idx), 32'(v[k].idx));
      addr = ~addr;
      rmrd = ~rmrd;
      wait_ack(n, cyc);
      chk({n, " ack cycle"}, 32'(cyc), 32'(v[k].ack_cyc));
      chk({n, " bus_err"}, 32'(bus_err), 32'(v[k].err));
      tick();
      chk({n, " ack pulse"}, 32'(ack), 32'd0);
      chk({n, " cs_n hold"}, 32'(cs_n), 32'(v[k].cs));
      if (v[k].chk_idx)
         chk({n, " idx hold"}, 32'(hit_idx), 32'(v[k].idx));
      req = 1'b0;
      tick();
      chk({n, " cs_n rel"}, 32'(cs_n), 32'hF);
      chk({n, " busy rel"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int cyc;
      v[0]  = '{16'h5F85, 1'b1, 4'b1110, 2'd0, 1'b1, 3, 1'b0};
      v[1]  = '{16'h0123, 1'b0, 4'b1101, 2'd1, 1'b1, 2, 1'b0};
      v[2]  = '{16'h0123, 1'b1, 4'b1011, 2'd2, 1'b1, 4, 1'b0};
      v[3]  = '{16'h6000, 1'b0, 4'b0111, 2'd3, 1'b1, 2, 1'b0};
      v[4]  = '{16'h9000, 1'b0, 4'b1111, 2'd0, 1'b0, 2, ERR_EXP};
      v[5]  = '{16'h5F80, 1'b0, 4'b1110, 2'd0, 1'b1, 3, 1'b0};
      v[6]  = '{16'h5FFF, 1'b1, 4'b1110, 2'd0, 1'b1, 3, 1'b0};
      v[7]  = '{16'h5F7F, 1'b0, 4'b0111, 2'd3, 1'b1, 2, 1'b0};
      v[8]  = '{16'h03FF, 1'b0, 4'b1101, 2'd1, 1'b1, 2, 1'b0};
      v[9]  = '{16'h0400, 1'b0, 4'b1111, 2'd0, 1'b0, 2, ERR_EXP};
      v[10] = '{16'h3FFF, 1'b1, 4'b1111, 2'd0, 1'b0, 2, ERR_EXP};
      v[11] = '{16'h7FFF, 1'b1, 4'b0111, 2'd3, 1'b1, 2, 1'b0};

      reset = 1'b1;
      req = 1'b1;
      addr = 16'h6000;
      rmrd = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst cs_n", 32'(cs_n), 32'hF);
         chk("rst ack", 32'(ack), 32'd0);
         chk("rst busy", 32'(busy), 32'd0);
         chk("rst bus_err", 32'(bus_err), 32'd0);
         chk("rst hit_idx", 32'(hit_idx), 32'd0);
      end
      reset = 1'b0;
      tick();
      chk("post-rst cs_n", 32'(cs_n), 32'b0111);
      chk("post-rst busy", 32'(busy), 32'd1);
      wait_ack("post-rst", cyc);
      chk("post-rst ack cycle", 32'(cyc), 32'd2);
      req = 1'b0;
      tick();
      tick();
      chk("post-rst rel", 32'(cs_n), 32'hF);

      for (int k = 0; k < 12; k++) run_vec(k);

      // Abort in WAIT: r2 has two wait states
      addr = 16'h0100;
      rmrd = 1'b1;
      req = 1'b1;
      tick();
      chk("abort cs_n T1", 32'(cs_n), 32'b1011);
      tick();
      chk("abort ack T2", 32'(ack), 32'd0);
      req = 1'b0;
      tick();
      chk("abort cs_n T3", 32'(cs_n), 32'hF);
      chk("abort ack T3", 32'(ack), 32'd0);
      chk("abort busy T3", 32'(busy), 32'd0);
      tick();
      chk("abort ack T4", 32'(ack), 32'd0);
      addr = 16'h0123;
      rmrd = 1'b0;
      req = 1'b1;
      tick();
      chk("after abort cs_n", 32'(cs_n), 32'b1101);
      chk("after abort idx", 32'(hit_idx), 32'd1);
      wait_ack("after abort", cyc);
      chk("after abort ack cycle", 32'(cyc), 32'd2);

      // req dropped in the ACK cycle itself
      req = 1'b0;
      tick();
      chk("late rel HOLD cs_n", 32'(cs_n), 32'b1101);
      chk("late rel HOLD busy", 32'(busy), 32'd1);
      tick();
      chk("late rel cs_n", 32'(cs_n), 32'hF);
      chk("late rel busy", 32'(busy), 32'd0);

      // Reset asserted while in HOLD
      addr = 16'h6000;
      req = 1'b1;
      tick();
      wait_ack("hold rst", cyc);
      tick();
      chk("hold rst pre cs_n", 32'(cs_n), 32'b0111);
      reset = 1'b1;
      tick();
      chk("hold rst cs_n", 32'(cs_n), 32'hF);
      chk("hold rst busy", 32'(busy), 32'd0);
      chk("hold rst ack", 32'(ack), 32'd0);
      chk("hold rst idx", 32'(hit_idx), 32'd0);
      req = 1'b0;
      reset = 1'b0;
      tick();
      chk("idle cs_n", 32'(cs_n), 32'hF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
